rv_hex_ctrl: RTL and testbench

// - Memory-mapped seven-segment display peripheral on the data bus, downstream of rv_mmu.
// - Receives the translated address and the shared request; returns the rvalid/rdata pair that rv_mmu selects for ADDRESS_HEX.
// - Holds one control/data register and drives NUM_DIGITS active-low 7-segment outputs from registered hex decoders.

---
 rtl/rv_hex_ctrl.sv | 119 +++++++++++
 tb/tb_rv_hex_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/rv_hex_ctrl.sv
// Memory-mapped six-digit seven-segment display peripheral with one control/data word.
// Optional blink support is compiled in with the HEX_BLINK_EN macro.
module rv_hex_ctrl #(
    parameter int                XLEN       = 32,
    parameter logic [XLEN-1:0]   ADDR       = 32'h0000_2000,
    parameter int                NUM_DIGITS = 6,
    parameter int                BLINK_DIV  = 25_000_000,
    parameter logic [31:0]       RESET_VAL  = 32'h0
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    data_req_i,
    input  logic                    data_we_i,
    input  logic [XLEN/8-1:0]       data_be_i,
    input  logic [XLEN-1:0]         data_addr_i,
    input  logic [XLEN-1:0]         data_wdata_i,
    output logic                    data_rvalid_o,
    output logic [XLEN-1:0]         data_rdata_o,
    output logic [7*NUM_DIGITS-1:0] hex_o
);

`ifdef HEX_BLINK_EN
    localparam logic [31:0] REG_MASK = 32'hBFFF_FFFF;
`else
    localparam logic [31:0] REG_MASK = 32'h3FFF_FFFF;
`endif

    logic                    hit;
    logic                    blank_phase;
    logic [31:0]             reg_q, reg_d;
    logic                    rvalid_q;
    logic [XLEN-1:0]         rdata_q;
    logic [7*NUM_DIGITS-1:0] hex_q, hex_d;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign hit = data_req_i && (data_addr_i == ADDR);

    always_comb begin
        reg_d = reg_q;
        if (hit && data_we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (data_be_i[b]) reg_d[8*b +: 8] = data_wdata_i[8*b +: 8];
            end
        end
        reg_d = reg_d & REG_MASK;
    end

`ifdef HEX_BLINK_EN
    localparam int CW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    logic [CW-1:0] blink_cnt_q;
    logic          phase_on_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            blink_cnt_q <= '0;
            phase_on_q  <= 1'b1;
        end else if (blink_cnt_q == CW'(BLINK_DIV - 1)) begin
            blink_cnt_q <= '0;
            phase_on_q  <= ~phase_on_q;
        end else begin
            blink_cnt_q <= blink_cnt_q + 1'b1;
        end
    end

    assign blank_phase = reg_q[31] && !phase_on_q;
`else
    assign blank_phase = 1'b0;
`endif

    // Digits decode from the stored register, so a write appears one edge after capture.
    always_comb begin
        hex_d = '1;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (reg_q[24+d] && !blank_phase) hex_d[7*d +: 7] = seg7(reg_q[4*d +: 4]);
            else                             hex_d[7*d +: 7] = 7'h7F;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            reg_q    <= RESET_VAL & REG_MASK;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            hex_q    <= '1;
        end else begin
            reg_q    <= reg_d;
            rvalid_q <= hit;
            if (hit) rdata_q <= XLEN'(reg_q);
            hex_q    <= hex_d;
        end
    end

    assign data_rvalid_o = rvalid_q;
    assign data_rdata_o  = rdata_q;
    assign hex_o         = hex_q;

endmodule

// File: tb/tb_rv_hex_ctrl.sv
// Directed bench for rv_hex_ctrl: bus vector table, mid-transaction reset and blink sequence.
// Covers both builds; the blink sequence adapts to whether HEX_BLINK_EN is defined.
module tb_rv_hex_ctrl;
    localparam logic [31:0] A = 32'h0000_2000;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        data_req_i, data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i, data_wdata_i;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic [41:0] hex_o;

    int nchk  = 0;
    int nfail = 0;

    rv_hex_ctrl #(.XLEN(32), .ADDR(A), .NUM_DIGITS(6), .BLINK_DIV(4), .RESET_VAL(32'h0)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
        .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
        .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .hex_o(hex_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        req, we;
        logic [3:0]  be;
        logic [31:0] addr, wdata;
        logic        exp_rv;
        logic [31:0] exp_rd;
        logic        chk_hex;
        logic [41:0] exp_hex;
    } vec_t;

    vec_t vecs[20];

    function automatic logic [41:0] hx(input logic [6:0] d5, d4, d3, d2, d1, d0);
        return {d5, d4, d3, d2, d1, d0};
    endfunction

    function automatic vec_t mk(input logic req, we, input logic [3:0] be, input logic [31:0] addr, wdata,
                                input logic rv, input logic [31:0] rd, input logic ch, input logic [41:0] h);
        vec_t v;
        v.req = req; v.we = we; v.be = be; v.addr = addr; v.wdata = wdata;
        v.exp_rv = rv; v.exp_rd = rd; v.chk_hex = ch; v.exp_hex = h;
        return v;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive one bus cycle, then return 1 time unit after the capturing edge.
    task automatic cyc(input logic req, we, input logic [3:0] be, input logic [31:0] addr, wdata);
        data_req_i = req; data_we_i = we; data_be_i = be; data_addr_i = addr; data_wdata_i = wdata;
        @(posedge clk_i);
        #1;
    endtask

    logic [41:0] all40, all7f;
    logic [6:0]  s[24];
    int          edge_i;

    initial begin
        all40 = hx(7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40);
        all7f = '1;

        vecs[0]  = mk(1, 1, 4'hF, A,     32'h3F123456, 1, 32'h00000000, 0, '0);
        vecs[1]  = mk(1, 0, 4'h0, A,     32'h0,        1, 32'h3F123456, 1, hx(7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02));
        vecs[2]  = mk(0, 0, 4'h0, A,     32'h0,        0, 32'h3F123456, 1, hx(7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02));
        vecs[3]  = mk(1, 1, 4'h2, A,     32'h0000AB00, 1, 32'h3F123456, 0, '0);
        vecs[4]  = mk(1, 0, 4'h0, A,     32'h0,        1, 32'h3F12AB56, 1, hx(7'h79, 7'h24, 7'h08, 7'h03, 7'h12, 7'h02));
        vecs[5]  = mk(1, 1, 4'hF, A,     32'h3F000000, 1, 32'h3F12AB56, 0, '0);
        vecs[6]  = mk(1, 0, 4'h0, A,     32'h0,        1, 32'h3F000000, 1, all40);
        vecs[7]  = mk(1, 1, 4'hF, A + 4, 32'hFFFFFFFF, 0, 32'h3F000000, 1, all40);
        vecs[8]  = mk(0, 1, 4'hF, A,     32'hFFFFFFFF, 0, 32'h3F000000, 1, all40);
        vecs[9]  = mk(1, 0, 4'h0, A,     32'h0,        1, 32'h3F000000, 1, all40);
        vecs[10] = mk(1, 1, 4'hF, A,     32'h40FFFFFF, 1, 32'h3F000000, 0, '0);
        vecs[11] = mk(1, 0, 4'h0, A,     32'h0,        1, 32'h00FFFFFF, 1, all7f);
        vecs[12] = mk(1, 1, 4'h8, A,     32'h3C000000, 1, 32'h00FFFFFF, 0, '0);
        vecs[13] = mk(1, 0, 4'h0, A,     32'h0,        1, 32'h3CFFFFFF, 1, hx(7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h7F, 7'h7F));
        vecs[14] = mk(1, 1, 4'h0, A,     32'h0,        1, 32'h3CFFFFFF, 0, '0);
        vecs[15] = mk(1, 0, 4'h0, A,     32'h0,        1, 32'h3CFFFFFF, 1, hx(7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h7F, 7'h7F));
        vecs[16] = mk(1, 1, 4'hF, A,     32'h3F789ABC, 1, 32'h3CFFFFFF, 0, '0);
        vecs[17] = mk(1, 0, 4'h0, A,     32'h0,        1, 32'h3F789ABC, 1, hx(7'h78, 7'h00, 7'h10, 7'h08, 7'h03, 7'h46));
        vecs[18] = mk(1, 1, 4'hF, A,     32'h3FDEF012, 1, 32'h3F789ABC, 0, '0);
        vecs[19] = mk(1, 0, 4'h0, A,     32'h0,        1, 32'h3FDEF012, 1, hx(7'h21, 7'h06, 7'h0E, 7'h40, 7'h79, 7'h24));

        rst_ni = 1'b0;
        data_req_i = 0; data_we_i = 0; data_be_i = '0; data_addr_i = '0; data_wdata_i = '0;
        repeat (3) @(posedge clk_i);
        #1;
        check("reset_rvalid", 64'(data_rvalid_o), 64'h0);
        check("reset_rdata",  64'(data_rdata_o),  64'h0);
        check("reset_hex",    64'(hex_o),         64'(all7f));
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        for (int i = 0; i < 20; i++) begin
            cyc(vecs[i].req, vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wdata);
            check($sformatf("vec%0d_rvalid", i), 64'(data_rvalid_o), 64'(vecs[i].exp_rv));
            check($sformatf("vec%0d_rdata", i),  64'(data_rdata_o),  64'(vecs[i].exp_rd));
            if (vecs[i].chk_hex) check($sformatf("vec%0d_hex", i), 64'(hex_o), 64'(vecs[i].exp_hex));
        end

        // Reset arriving while a hit is being presented: its response must never appear.
        data_req_i = 1; data_we_i = 0; data_addr_i = A;
        #3;
        rst_ni = 1'b0;
        #1;
        check("midrst_rvalid", 64'(data_rvalid_o), 64'h0);
        check("midrst_hex",    64'(hex_o),         64'(all7f));
        @(posedge clk_i);
        data_req_i = 0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        check("postrst_rvalid", 64'(data_rvalid_o), 64'h0);
        check("postrst_rdata",  64'(data_rdata_o),  64'h0);
        cyc(1, 0, 4'h0, A, 32'h0);
        check("postrst_read_rvalid", 64'(data_rvalid_o), 64'h1);
        check("postrst_read_rdata",  64'(data_rdata_o),  64'h0);

        cyc(1, 1, 4'hF, A, 32'h81000001);
        cyc(1, 0, 4'h0, A, 32'h0);
`ifdef HEX_BLINK_EN
        check("blink_read", 64'(data_rdata_o), 64'h81000001);
        cyc(0, 0, 4'h0, A, 32'h0);
        for (int k = 0; k < 24; k++) begin
            s[k] = hex_o[6:0];
            check($sformatf("blink_dig1_%0d", k), 64'(hex_o[13:7]), 64'h7F);
            cyc(0, 0, 4'h0, A, 32'h0);
        end
        edge_i = -1;
        for (int k = 1; k < 24; k++) if (edge_i < 0 && s[k] != s[k-1]) edge_i = k;
        check("blink_toggles", 64'(edge_i > 0 && edge_i <= 4), 64'h1);
        if (edge_i > 0) begin
            for (int k = edge_i; k < 24; k++)
                check($sformatf("blink_hex0_%0d", k), 64'(s[k]),
                      64'((((k - edge_i) / 4) % 2 == 0) ? s[edge_i] : s[edge_i-1]));
            check("blink_levels", 64'({s[edge_i], s[edge_i-1]} == {7'h79, 7'h7F} ||
                                      {s[edge_i], s[edge_i-1]} == {7'h7F, 7'h79}), 64'h1);
        end
        cyc(1, 1, 4'h8, A, 32'h01000000);
        cyc(0, 0, 4'h0, A, 32'h0);
        for (int k = 0; k < 10; k++) begin
            check($sformatf("unblink_hex0_%0d", k), 64'(hex_o[6:0]), 64'h79);
            cyc(0, 0, 4'h0, A, 32'h0);
        end
`else
        check("noblink_read", 64'(data_rdata_o), 64'h01000001);
        for (int k = 0; k < 12; k++) begin
            check($sformatf("noblink_hex0_%0d", k), 64'(hex_o[6:0]), 64'h79);
            check($sformatf("noblink_dig1_%0d", k), 64'(hex_o[13:7]), 64'h7F);
            cyc(0, 0, 4'h0, A, 32'h0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, expected finish before 100000");
        $fatal(1);
    end
endmodule
